ledram_frame_sched: RTL



---
 rtl/ledram_pkg.sv | 16 +
 rtl/ledram_frame_sched_if.sv | 22 ++
 rtl/ledram_frame_arb.sv | 47 ++++
 rtl/ledram_frame_sched.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/ledram_pkg.sv
// Shared types and timing offsets for the MiniLED frame-RAM scheduler.
package ledram_pkg;
  typedef enum logic {CFG = 1'b0, FRAME = 1'b1} state_e;

  // Owner codes double as the one-hot grant / read-strobe mask.
  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_SRC0 = 2'b01,
    OWN_SRC1 = 2'b10
  } owner_e;

  localparam int RD_START     = 4;
  localparam int WR_START     = 6;
  localparam int DEF_NUM_LEDS = 360;
  localparam int DEF_DW       = 16;
endpackage

// File: rtl/ledram_frame_sched_if.sv
// Pixel-source handshake and frame-RAM write bus of the frame scheduler.
interface ledram_frame_sched_if #(
  parameter int AW = 10,
  parameter int DW = 16
);
  logic [1:0]    req, gnt, owner, pix_rd;
  logic [AW-1:0] pix_addr, wtaddr_wire;
  logic [DW-1:0] pix_data0, pix_data1, wtdina_wire;
  logic          sdbpflag_wire, wtwe, cfg_done, frame_done;

  modport master (
    input  req, pix_data0, pix_data1,
    output gnt, owner, pix_rd, pix_addr, sdbpflag_wire, wtwe, wtaddr_wire,
           wtdina_wire, cfg_done, frame_done
  );

  modport slave (
    output req, pix_data0, pix_data1,
    input  gnt, owner, pix_rd, pix_addr, sdbpflag_wire, wtwe, wtaddr_wire,
           wtdina_wire, cfg_done, frame_done
  );
endinterface

// File: rtl/ledram_frame_arb.sv
// Per-frame owner decision; src1 wins contested frames until it has won
// STARVE_LIM of them in a row, then src0 gets one.
module ledram_frame_arb
  import ledram_pkg::*;
#(
  parameter int STARVE_LIM = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       t0,
  output owner_e     nxt_owner
);
  localparam int SW = $clog2(STARVE_LIM + 2);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

  logic [SW-1:0] starve_q, starve_d;

  always_comb begin
    nxt_owner = OWN_NONE;
    starve_d  = starve_q;
    case (req)
      2'b01: nxt_owner = OWN_SRC0;
      2'b10: begin
        nxt_owner = OWN_SRC1;
        starve_d  = '0;
      end
      2'b11: begin
        if (starve_q == LIM) begin
          nxt_owner = OWN_SRC0;
          starve_d  = '0;
        end else begin
          nxt_owner = OWN_SRC1;
          starve_d  = starve_q + 1'b1;
        end
      end
      default: nxt_owner = OWN_NONE;
    endcase
    // Only the frame-start decision is committed.
    if (!t0) starve_d = starve_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_q <= '0;
    else        starve_q <= starve_d;
  end
endmodule

// File: rtl/ledram_frame_sched.sv
// Frame scheduler: config wait, then periodic frames that grant the RAM write
// port, pulse sdbpflag and stream NUM_LEDS pixels from the owner into RAM.
module ledram_frame_sched
  import ledram_pkg::*;
#(
  parameter int NUM_LEDS     = DEF_NUM_LEDS,
  parameter int CFG_WAIT     = 2500,
  parameter int FRAME_PERIOD = 420000,
  parameter int FLAG_LEN     = 29,
  parameter int STARVE_LIM   = 4,
  parameter int DW           = DEF_DW,
  parameter int AW           = 10
) (
  input logic                  clk,
  input logic                  rst_n,
  ledram_frame_sched_if.master bus
);
  localparam int CMAX = (CFG_WAIT > FRAME_PERIOD) ? CFG_WAIT : FRAME_PERIOD;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [CW-1:0] CFG_LAST = CW'(CFG_WAIT - 1);
  localparam logic [CW-1:0] FP       = CW'(FRAME_PERIOD);
  localparam logic [CW-1:0] FLAG_HI  = CW'(FLAG_LEN);
  localparam logic [CW-1:0] RD_LO    = CW'(RD_START);
  localparam logic [CW-1:0] RD_HI    = CW'(RD_START + NUM_LEDS - 1);
  localparam logic [CW-1:0] WR_LO    = CW'(WR_START);
  localparam logic [CW-1:0] WR_HI    = CW'(WR_START + NUM_LEDS - 1);
  localparam logic [CW-1:0] DONE_AT  = CW'(WR_START + NUM_LEDS);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  owner_e        owner_q, owner_d, arb_owner;
  logic [1:0]    gnt_q, gnt_d, pix_rd_q, pix_rd_d;
  logic [AW-1:0] pix_addr_q, pix_addr_d, wtaddr_q, wtaddr_d;
  logic [DW-1:0] wtdina_q, wtdina_d;
  logic          cfg_done_q, cfg_done_d, sdb_q, sdb_d, wtwe_q, wtwe_d;
  logic          frame_done_q, frame_done_d, t0;

  assign t0 = (state_q == FRAME) && (cnt_q == '0);

  ledram_frame_arb #(.STARVE_LIM(STARVE_LIM)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (bus.req),
    .t0        (t0),
    .nxt_owner (arb_owner)
  );

  // All outputs are decoded from the next counter value so they land
  // registered exactly on the frame-relative cycle they belong to.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cfg_done_d   = cfg_done_q;
    owner_d      = owner_q;
    gnt_d        = '0;
    pix_rd_d     = '0;
    pix_addr_d   = '0;
    sdb_d        = 1'b0;
    wtwe_d       = 1'b0;
    wtaddr_d     = '0;
    wtdina_d     = '0;
    frame_done_d = 1'b0;
    case (state_q)
      CFG: begin
        if (cnt_q == CFG_LAST) begin
          state_d    = FRAME;
          cnt_d      = '0;
          cfg_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FRAME: begin
        cnt_d = (cnt_q == FP) ? '0 : cnt_q + 1'b1;
        if (t0) begin
          owner_d = arb_owner;
          gnt_d   = arb_owner;
        end
        sdb_d = (cnt_d != '0) && (cnt_d <= FLAG_HI);
        if (cnt_d >= RD_LO && cnt_d <= RD_HI) begin
          pix_rd_d   = owner_d;
          pix_addr_d = AW'(cnt_d - RD_LO);
        end
        // A frame with no owner still writes, as blank pixels.
        if (cnt_d >= WR_LO && cnt_d <= WR_HI) begin
          wtwe_d   = 1'b1;
          wtaddr_d = AW'(cnt_d - WR_LO);
          case (owner_q)
            OWN_SRC0: wtdina_d = bus.pix_data0;
            OWN_SRC1: wtdina_d = bus.pix_data1;
            default:  wtdina_d = '0;
          endcase
        end
        frame_done_d = (cnt_d == DONE_AT);
      end
      default: state_d = CFG;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= CFG;
      cnt_q        <= '0;
      cfg_done_q   <= 1'b0;
      owner_q      <= OWN_NONE;
      gnt_q        <= '0;
      pix_rd_q     <= '0;
      pix_addr_q   <= '0;
      sdb_q        <= 1'b0;
      wtwe_q       <= 1'b0;
      wtaddr_q     <= '0;
      wtdina_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cfg_done_q   <= cfg_done_d;
      owner_q      <= owner_d;
      gnt_q        <= gnt_d;
      pix_rd_q     <= pix_rd_d;
      pix_addr_q   <= pix_addr_d;
      sdb_q        <= sdb_d;
      wtwe_q       <= wtwe_d;
      wtaddr_q     <= wtaddr_d;
      wtdina_q     <= wtdina_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.owner         = owner_q;
  assign bus.pix_rd        = pix_rd_q;
  assign bus.pix_addr      = pix_addr_q;
  assign bus.sdbpflag_wire = sdb_q;
  assign bus.wtwe          = wtwe_q;
  assign bus.wtaddr_wire   = wtaddr_q;
  assign bus.wtdina_wire   = wtdina_q;
  assign bus.cfg_done      = cfg_done_q;
  assign bus.frame_done    = frame_done_q;
endmodule
